clk_div_monitor: RTL and testbench

//   Receive-side checker for the frequency-divider blocks (divide-by-3 and others).

---
 rtl/clk_div_monitor.sv | 171 +++++++++++++++++
 tb/tb_clk_div_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divide-ratio monitor for a divided clock sampled in the clk domain.
// Each period (rise to rise) and its high time are measured in clk cycles.
// Lock is declared after LOCK_CNT consecutive periods of EXP_DIV.
// A period that differs from EXP_DIV pulses err_mismatch.
// No rise for TIMEOUT cycles sets the sticky err_timeout.
module clk_div_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_DIV  = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_mismatch,
  output logic             err_timeout
);

  // LOCK_CNT is at most 15, so four bits always hold the streak.
  localparam int unsigned MatchW = 4;

  localparam logic [CNT_W-1:0]  ExpDivC  = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0]  TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  OneC     = CNT_W'(1);
  localparam logic [MatchW-1:0] LockCntC = MatchW'(LOCK_CNT);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic               div_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d;
  logic               err_mismatch_q, err_mismatch_d;
  logic               err_timeout_q, err_timeout_d;
  logic               rise;

  // Rising edge of the divided clock, relative to the previous clk sample.
  assign rise = div_in & ~div_q;

  // Next-state and output decode; everything holds unless a rule below changes it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hcnt_d         = hcnt_q;
    match_d        = match_q;
    period_d       = period_q;
    high_d         = high_q;
    meas_valid_d   = 1'b0;
    locked_d       = locked_q;
    err_mismatch_d = 1'b0;
    err_timeout_d  = err_timeout_q;

    if (!en) begin
      // Disabling wipes all measurement state, including the sticky error.
      state_d       = StIdle;
      cnt_d         = '0;
      hcnt_d        = '0;
      match_d       = '0;
      period_d      = '0;
      high_d        = '0;
      locked_d      = 1'b0;
      err_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
        end

        StArm: begin
          // The first rise only starts a period; nothing is reported for it.
          if (rise) begin
            cnt_d   = OneC;
            hcnt_d  = OneC;
            state_d = StMeas;
          end
        end

        StMeas: begin
          if (rise) begin
            // A rise always closes the period, even when cnt has reached TIMEOUT.
            period_d     = cnt_q;
            high_d       = hcnt_q;
            meas_valid_d = 1'b1;
            cnt_d        = OneC;
            hcnt_d       = OneC;
            if (cnt_q == ExpDivC) begin
              if (match_q < LockCntC) begin
                match_d = match_q + MatchW'(1);
              end
              if (match_d == LockCntC) begin
                locked_d = 1'b1;
              end
            end else begin
              match_d        = '0;
              locked_d       = 1'b0;
              err_mismatch_d = 1'b1;
            end
          end else if (cnt_q == TimeoutC) begin
            state_d       = StErr;
            err_timeout_d = 1'b1;
            locked_d      = 1'b0;
            match_d       = '0;
          end else begin
            cnt_d  = cnt_q + OneC;
            hcnt_d = hcnt_q + CNT_W'(div_in);
          end
        end

        StErr: begin
          // Parked until en drops; reported values stay frozen.
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers; the input sampler runs in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      div_q          <= 1'b0;
      cnt_q          <= '0;
      hcnt_q         <= '0;
      match_q        <= '0;
      period_q       <= '0;
      high_q         <= '0;
      meas_valid_q   <= 1'b0;
      locked_q       <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_in;
      cnt_q          <= cnt_d;
      hcnt_q         <= hcnt_d;
      match_q        <= match_d;
      period_q       <= period_d;
      high_q         <= high_d;
      meas_valid_q   <= meas_valid_d;
      locked_q       <= locked_d;
      err_mismatch_q <= err_mismatch_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign meas_valid   = meas_valid_q;
  assign locked       = locked_q;
  assign err_mismatch = err_mismatch_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios followed by random waveforms.
// Expected values come from a timestamp/sample-history model of the measurement rules.
module tb_clk_div_monitor;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned EXP_DIV  = 3;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned TIMEOUT  = 20;

  logic             clk;
  logic             rst;
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_mismatch;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 disabled, 1 waiting for first rise, 2 measuring, 3 stuck
  int   m_phase;
  logic m_prev;
  int   m_hist[$];  // div_in samples taken since the last counted rise
  int   m_streak;
  int   e_period;
  int   e_high;
  logic e_valid;
  logic e_locked;
  logic e_mis;
  logic e_tmo;

  clk_div_monitor #(
    .CNT_W   (CNT_W),
    .EXP_DIV (EXP_DIV),
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_in      (div_in),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_mismatch(err_mismatch),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_prev   = 1'b0;
    m_hist.delete();
    m_streak = 0;
    e_period = 0;
    e_high   = 0;
    e_valid  = 1'b0;
    e_locked = 1'b0;
    e_mis    = 1'b0;
    e_tmo    = 1'b0;
  endtask

  // Apply the measurement rules for one sampled (en, div_in) pair.
  task automatic model_step(input logic e, input logic d);
    logic r;
    int   n;
    int   ones;
    r       = d && !m_prev;
    m_prev  = d;
    e_valid = 1'b0;
    e_mis   = 1'b0;
    if (!e) begin
      m_phase  = 0;
      m_hist.delete();
      m_streak = 0;
      e_period = 0;
      e_high   = 0;
      e_locked = 1'b0;
      e_tmo    = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (r) begin
        m_phase = 2;
        m_hist.delete();
        m_hist.push_back(1);
      end
    end else if (m_phase == 2) begin
      n = m_hist.size();
      if (r) begin
        ones = 0;
        foreach (m_hist[i]) ones += m_hist[i];
        e_period = n;
        e_high   = ones;
        e_valid  = 1'b1;
        if (n == EXP_DIV) begin
          m_streak = (m_streak + 1 > LOCK_CNT) ? LOCK_CNT : m_streak + 1;
          if (m_streak == LOCK_CNT) e_locked = 1'b1;
        end else begin
          m_streak = 0;
          e_locked = 1'b0;
          e_mis    = 1'b1;
        end
        m_hist.delete();
        m_hist.push_back(1);
      end else if (n == TIMEOUT) begin
        m_phase  = 3;
        m_streak = 0;
        e_locked = 1'b0;
        e_tmo    = 1'b1;
      end else begin
        m_hist.push_back(d ? 1 : 0);
      end
    end
  endtask

  task automatic check_all();
    chk("period", period, 8'(e_period));
    chk("high_time", high_time, 8'(e_high));
    chk("meas_valid", {7'b0, meas_valid}, {7'b0, e_valid});
    chk("locked", {7'b0, locked}, {7'b0, e_locked});
    chk("err_mismatch", {7'b0, err_mismatch}, {7'b0, e_mis});
    chk("err_timeout", {7'b0, err_timeout}, {7'b0, e_tmo});
  endtask

  task automatic cycle(input logic e, input logic d);
    en     = e;
    div_in = d;
    @(posedge clk);
    model_step(e, d);
    #1;
    check_all();
  endtask

  // One period of div_in: h high samples followed by p-h low samples.
  task automatic wave(input int p, input int h);
    for (int i = 0; i < p; i++) cycle(1'b1, (i < h) ? 1'b1 : 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period, 8'd0);
    chk({tag, "_high"}, high_time, 8'd0);
    chk({tag, "_valid"}, {7'b0, meas_valid}, 8'd0);
    chk({tag, "_locked"}, {7'b0, locked}, 8'd0);
    chk({tag, "_mis"}, {7'b0, err_mismatch}, 8'd0);
    chk({tag, "_tmo"}, {7'b0, err_timeout}, 8'd0);
  endtask

  initial begin
    int sel;
    int p;
    int h;
    model_reset();
    rst    = 1'b0;
    en     = 1'b0;
    div_in = 1'b0;
    #3;
    chk_all_zero("reset");
    #9;
    rst = 1'b1;

    // Divide-by-3: lock after four matching measurements
    for (int i = 0; i < 7; i++) wave(3, 1);
    chk("t1_locked", {7'b0, locked}, 8'd1);

    // Switch to divide-by-4 while locked
    for (int i = 0; i < 3; i++) wave(4, 2);
    chk("t2_period", period, 8'd4);
    chk("t2_high", high_time, 8'd2);
    chk("t2_locked", {7'b0, locked}, 8'd0);

    // Stuck low after a rise in MEAS
    for (int i = 0; i < 6; i++) wave(3, 1);
    chk("t3_locked_before", {7'b0, locked}, 8'd1);
    cycle(1'b1, 1'b1);
    repeat (24) cycle(1'b1, 1'b0);
    chk("t3_tmo", {7'b0, err_timeout}, 8'd1);
    chk("t3_locked", {7'b0, locked}, 8'd0);
    cycle(1'b0, 1'b0);
    chk("t3_tmo_clr", {7'b0, err_timeout}, 8'd0);
    chk("t3_period_clr", period, 8'd0);

    // Stuck high: timeout with high_time frozen at its last value
    for (int i = 0; i < 6; i++) wave(3, 1);
    repeat (25) cycle(1'b1, 1'b1);
    chk("t4_tmo", {7'b0, err_timeout}, 8'd1);
    chk("t4_high", high_time, 8'd1);
    cycle(1'b0, 1'b0);

    // Asynchronous reset mid-period while locked
    for (int i = 0; i < 6; i++) wave(3, 1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    chk("t5_locked_before", {7'b0, locked}, 8'd1);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    #3;
    rst = 1'b1;
    for (int i = 0; i < 7; i++) wave(3, 1);
    chk("t5_relock", {7'b0, locked}, 8'd1);

    // Rise lands exactly when cnt reaches TIMEOUT
    wave(TIMEOUT, 1);
    cycle(1'b1, 1'b1);
    chk("t6_valid", {7'b0, meas_valid}, 8'd1);
    chk("t6_period", period, 8'(TIMEOUT));
    chk("t6_mis", {7'b0, err_mismatch}, 8'd1);
    chk("t6_tmo", {7'b0, err_timeout}, 8'd0);

    // Random waveforms, enable drops and stuck levels
    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        repeat ($urandom_range(1, 2)) cycle(1'b0, 1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        h = int'($urandom_range(0, 1));
        repeat ($urandom_range(15, 30)) cycle(1'b1, h[0]);
      end else begin
        p = (sel < 6) ? EXP_DIV : int'($urandom_range(2, TIMEOUT + 2));
        h = int'($urandom_range(1, p - 1));
        wave(p, h);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
